coeff_wr_ctrl: RTL

Write-side controller for the coefficient memory; it is the producer end of the read-pointer/valid-bitmap interface used by the coefficient read counter. It accepts a coefficient stream over a valid/ready handshake, writes each beat into consecutive memory addresses, and publishes a per-entry written bitmap (`count_o`) and a `loaded_o` flag. It sits between the coefficient load path (host/DMA) and the coefficient memory, in parallel with the read counter.

---
 rtl/coeff_wr_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/coeff_wr_ctrl.sv
// Coefficient memory write-side controller: accepts a valid/ready coefficient
// stream, writes consecutive addresses and publishes a written bitmap plus a loaded flag.
module coeff_wr_ctrl #(
  parameter int ADDR_LINES = 4,
  parameter int DATA_W     = 16,
  localparam int DEPTH     = 1 << ADDR_LINES
) (
  input  logic                  clkn_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_W-1:0]     s_data_i,
  input  logic                  s_last_i,
  output logic                  mem_we_o,
  output logic [ADDR_LINES-1:0] mem_waddr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DEPTH-1:0]      count_o,
  output logic [ADDR_LINES-1:0] wr_ptr_o,
  output logic                  loaded_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_LINES-1:0] LAST_ADDR = {ADDR_LINES{1'b1}};
  localparam logic [DEPTH-1:0]      ONE_BIT   = {{(DEPTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    we_q, we_d;
  logic [ADDR_LINES-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DEPTH-1:0]        count_q, count_d;
  logic [ADDR_LINES-1:0]   ptr_q, ptr_d;
  logic                    loaded_q, loaded_d;
  logic                    err_q, err_d;
  logic                    hs_s;

  assign hs_s = s_valid_i && ready_q;

  // Next-state and output computation; start_i overrides any same-cycle beat.
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    err_d    = err_q;

    if (start_i) begin
      state_d  = ST_LOAD;
      count_d  = {DEPTH{1'b0}};
      ptr_d    = {ADDR_LINES{1'b0}};
      loaded_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (hs_s) begin
            we_d    = 1'b1;
            waddr_d = ptr_q;
            wdata_d = s_data_i;
            count_d = count_q | (ONE_BIT << ptr_q);
            // The pointer saturates at the top entry so nothing is overwritten.
            if (ptr_q != LAST_ADDR) begin
              ptr_d = ptr_q + {{(ADDR_LINES-1){1'b0}}, 1'b1};
            end else begin
              ptr_d = ptr_q;
            end
            if (s_last_i || (ptr_q == LAST_ADDR)) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_LOAD;
            end
            if ((ptr_q == LAST_ADDR) && !s_last_i) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_FLUSH: begin
          state_d  = ST_DONE;
          loaded_d = 1'b1;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ready_d = (state_d == ST_LOAD);
  end

  // State and output registers; reset drops any in-flight write immediately.
  always_ff @(posedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= {ADDR_LINES{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      count_q  <= {DEPTH{1'b0}};
      ptr_q    <= {ADDR_LINES{1'b0}};
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign s_ready_o   = ready_q;
  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign wr_ptr_o    = ptr_q;
  assign loaded_o    = loaded_q;
  assign err_o       = err_q;

endmodule
